// File: rtl/cart_detect.sv
// Cartridge type detector: snoops the ROM download stream, collects opcode
// signatures and an SC-RAM hint, and resolves bs/sc once the download ends.
module cart_detect (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [3:0]  ext_bs,
  input  logic [1:0]  sc_mode,
  output logic [3:0]  bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        valid
);
  typedef enum logic [1:0] {IDLE, LOAD, DECIDE, DONE} state_t;

  state_t          state_q, state_d;
  logic            dl_q, armed_q, armed_d;
  logic [4:0][7:0] win_q, win_d;
  logic [4:0]      wv_q, wv_d;
  logic            e0_q, e0_d, fe_q, fe_d, e7_q, e7_d, ua_q, ua_d;
  logic [1:0]      c3f_q, c3f_d;
  logic [7:0]      b0_q, b0_d;
  logic            b0_seen_q, b0_seen_d, sc_eq_q, sc_eq_d;
  logic [8:0]      sc_cnt_q, sc_cnt_d;
  logic [16:0]     size_q, size_d;
  logic [3:0]      bs_q, bs_d;
  logic            sc_q, sc_d, valid_q, valid_d;
  logic            rise, fall, wr, sc_auto, sc_size;

  // Low n bytes of pat (byte 0 = newest) against the window; empty slots never match.
  function automatic logic win_match(input logic [4:0][7:0] w, input logic [4:0] v,
                                     input logic [39:0] pat, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++)
      if (i < n && !(v[i] && w[i] == pat[8*i +: 8])) ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~ioctl_download;
    win_d     = win_q;
    wv_d      = wv_q;
    e0_d      = e0_q;
    fe_d      = fe_q;
    e7_d      = e7_q;
    ua_d      = ua_q;
    c3f_d     = c3f_q;
    b0_d      = b0_q;
    b0_seen_d = b0_seen_q;
    sc_eq_d   = sc_eq_q;
    sc_cnt_d  = sc_cnt_q;
    size_d    = size_q;
    bs_d      = bs_q;
    sc_d      = sc_q;
    valid_d   = valid_q;
    // A download already high when reset drops must go low once before it counts.
    rise      = ioctl_download & ~dl_q & armed_q;
    fall      = ~ioctl_download & dl_q;
    wr        = (state_q == LOAD) & ioctl_wr;
    sc_auto   = b0_seen_q & sc_eq_q & sc_cnt_q[8];
    sc_size   = (size_q == 17'd8192) || (size_q == 17'd12288) || (size_q == 17'd16384);

    case (state_q)
      IDLE, DONE: if (rise) begin
        state_d   = LOAD;
        valid_d   = 1'b0;
        size_d    = '0;
        win_d     = '0;
        wv_d      = '0;
        e0_d      = 1'b0;
        fe_d      = 1'b0;
        e7_d      = 1'b0;
        ua_d      = 1'b0;
        c3f_d     = '0;
        b0_d      = '0;
        b0_seen_d = 1'b0;
        sc_eq_d   = 1'b1;
        sc_cnt_d  = '0;
      end
      LOAD: if (fall) state_d = DECIDE;
      DECIDE: begin
        state_d = DONE;
        valid_d = 1'b1;
        if (ext_bs != 4'd0)            bs_d = ext_bs;
        else if (size_q <= 17'd4096)   bs_d = 4'd0;
        else begin
          case (size_q)
            17'd8192:  bs_d = e0_q ? 4'd4 : c3f_q[1] ? 4'd5 : fe_q ? 4'd3 : ua_q ? 4'd11 : 4'd1;
            17'd10495: bs_d = 4'd7;
            17'd12288: bs_d = 4'd8;
            17'd16384: bs_d = e7_q ? 4'd12 : c3f_q[1] ? 4'd5 : 4'd2;
            17'd32768: bs_d = c3f_q[1] ? 4'd5 : 4'd6;
            default:   bs_d = c3f_q[1] ? 4'd5 : 4'd0;
          endcase
        end
        sc_d = (sc_mode == 2'd0) ? (sc_auto & sc_size) : sc_mode[1];
      end
      default: state_d = IDLE;
    endcase

    if (wr) begin
      size_d = (ioctl_addr >= 25'h0_FFFF) ? 17'h10000 : ioctl_addr[16:0] + 17'd1;
      if (ioctl_addr[24:15] == 10'd0) begin
        if (ioctl_addr == 25'd0) wv_d = '0;
        win_d = {win_d[3:0], ioctl_dout};
        wv_d  = {wv_d[3:0], 1'b1};
        if (win_match(win_d, wv_d, 40'h8DE01F, 3) || win_match(win_d, wv_d, 40'h8DE05F, 3) ||
            win_match(win_d, wv_d, 40'h8DE9FF, 3) || win_match(win_d, wv_d, 40'hADE01F, 3))
          e0_d = 1'b1;
        if (win_match(win_d, wv_d, 40'h853F, 2) && !c3f_q[1]) c3f_d = c3f_q + 2'd1;
        if (win_match(win_d, wv_d, 40'h2000D0C6C5, 5)) fe_d = 1'b1;
        if (win_match(win_d, wv_d, 40'hADE2FF, 3) || win_match(win_d, wv_d, 40'hADE5FF, 3))
          e7_d = 1'b1;
        if (win_match(win_d, wv_d, 40'h8D4002, 3) || win_match(win_d, wv_d, 40'hAD4002, 3))
          ua_d = 1'b1;
      end
      if (!sc_cnt_q[8]) sc_cnt_d = sc_cnt_q + 9'd1;
      if (ioctl_addr < 25'd256) begin
        if (ioctl_addr == 25'd0) begin
          b0_d      = ioctl_dout;
          b0_seen_d = 1'b1;
        end else if (!b0_seen_q || ioctl_dout != b0_q) begin
          sc_eq_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dl_q      <= 1'b0;
      armed_q   <= 1'b0;
      win_q     <= '0;
      wv_q      <= '0;
      e0_q      <= 1'b0;
      fe_q      <= 1'b0;
      e7_q      <= 1'b0;
      ua_q      <= 1'b0;
      c3f_q     <= '0;
      b0_q      <= '0;
      b0_seen_q <= 1'b0;
      sc_eq_q   <= 1'b0;
      sc_cnt_q  <= '0;
      size_q    <= '0;
      bs_q      <= '0;
      sc_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= ioctl_download;
      armed_q   <= armed_d;
      win_q     <= win_d;
      wv_q      <= wv_d;
      e0_q      <= e0_d;
      fe_q      <= fe_d;
      e7_q      <= e7_d;
      ua_q      <= ua_d;
      c3f_q     <= c3f_d;
      b0_q      <= b0_d;
      b0_seen_q <= b0_seen_d;
      sc_eq_q   <= sc_eq_d;
      sc_cnt_q  <= sc_cnt_d;
      size_q    <= size_d;
      bs_q      <= bs_d;
      sc_q      <= sc_d;
      valid_q   <= valid_d;
    end
  end

  assign bs       = bs_q;
  assign sc       = sc_q;
  assign rom_size = size_q;
  assign valid    = valid_q;
endmodule

// File: tb/tb_cart_detect.sv
// Bench for cart_detect: directed loads plus randomized sparse loads checked
// against a byte-stream reference model.
module tb_cart_detect;
  logic        clk = 1'b0;
  logic        reset, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  ext_bs;
  logic [1:0]  sc_mode;
  logic [3:0]  bs;
  logic        sc, valid;
  logic [16:0] rom_size;

  always #5 clk = ~clk;

  cart_detect dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ext_bs(ext_bs), .sc_mode(sc_mode),
    .bs(bs), .sc(sc), .rom_size(rom_size), .valid(valid)
  );

  int         n_chk = 0, n_pass = 0;
  int         prev_bs = 0, prev_sc = 0;
  int         wq_a[$];
  logic [7:0] wq_d[$];
  logic [7:0] plan[0:511];
  logic [7:0] alpha[18] = '{8'h8D, 8'hE0, 8'h1F, 8'h5F, 8'hE9, 8'hFF, 8'hAD, 8'h85, 8'h3F,
                            8'h20, 8'h00, 8'hD0, 8'hC6, 8'hC5, 8'hE2, 8'hE5, 8'h40, 8'h02};
  logic [39:0] pats[10] = '{40'h8DE01F, 40'h8DE05F, 40'h8DE9FF, 40'hADE01F, 40'h853F,
                            40'h2000D0C6C5, 40'hADE2FF, 40'hADE5FF, 40'h8D4002, 40'hAD4002};
  int          plen[10] = '{3, 3, 3, 3, 2, 5, 3, 3, 3, 3};
  int          sizes[11] = '{2048, 4096, 4097, 8192, 10495, 12288, 16384, 20000, 32768,
                             65536, 70000};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Last n bytes of the stream (newest = byte 0 of p).
  function automatic bit tail_is(input logic [7:0] s[$], input logic [39:0] p, input int n);
    if (s.size() < n) return 1'b0;
    for (int k = 0; k < n; k++)
      if (s[s.size() - 1 - k] != p[8*k +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input logic [3:0] eb, input logic [1:0] scm,
                       output int ebs, output int esc, output int esz);
    logic [7:0] w[$];
    logic [7:0] b0;
    int n3f, a;
    bit e0, fe, e7, ua, seen0, eq;
    n3f = 0; e0 = 0; fe = 0; e7 = 0; ua = 0; seen0 = 0; eq = 1; b0 = 0; esz = 0;
    foreach (wq_a[i]) begin
      a   = wq_a[i];
      esz = (a + 1 > 65536) ? 65536 : a + 1;
      if (a == 0) begin
        b0 = wq_d[i]; seen0 = 1; w.delete();
      end else if (a < 256 && (!seen0 || wq_d[i] != b0)) eq = 0;
      if (a < 32768) begin
        w.push_back(wq_d[i]);
        if (w.size() > 5) void'(w.pop_front());
        if (tail_is(w, 40'h8DE01F, 3) || tail_is(w, 40'h8DE05F, 3) ||
            tail_is(w, 40'h8DE9FF, 3) || tail_is(w, 40'hADE01F, 3)) e0 = 1;
        if (tail_is(w, 40'h853F, 2)) n3f++;
        if (tail_is(w, 40'h2000D0C6C5, 5)) fe = 1;
        if (tail_is(w, 40'hADE2FF, 3) || tail_is(w, 40'hADE5FF, 3)) e7 = 1;
        if (tail_is(w, 40'h8D4002, 3) || tail_is(w, 40'hAD4002, 3)) ua = 1;
      end
    end
    if (eb != 0)              ebs = int'(eb);
    else if (esz <= 4096)     ebs = 0;
    else if (esz == 8192)     ebs = e0 ? 4 : (n3f >= 2) ? 5 : fe ? 3 : ua ? 11 : 1;
    else if (esz == 10495)    ebs = 7;
    else if (esz == 12288)    ebs = 8;
    else if (esz == 16384)    ebs = e7 ? 12 : (n3f >= 2) ? 5 : 2;
    else if (esz == 32768)    ebs = (n3f >= 2) ? 5 : 6;
    else                      ebs = (n3f >= 2) ? 5 : 0;
    if (scm == 0)
      esc = (seen0 && eq && wq_a.size() >= 256 &&
             (esz == 8192 || esz == 12288 || esz == 16384)) ? 1 : 0;
    else
      esc = int'(scm[1]);
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
    wq_a.push_back(a); wq_d.push_back(d);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    wq_a.delete(); wq_d.delete();
    ioctl_download = 1'b1;
    tick();
    chk("entry_valid", int'(valid), 0);
    chk("entry_size", int'(rom_size), 0);
    chk("entry_hold_bs", int'(bs), prev_bs);
  endtask

  task automatic mid_chk(input int a);
    chk("live_size", int'(rom_size), a + 1);
    chk("hold_bs", int'(bs), prev_bs);
    chk("hold_sc", int'(sc), prev_sc);
    chk("load_valid", int'(valid), 0);
  endtask

  task automatic end_load(input bit with_wr, input int a, input logic [7:0] d);
    ioctl_download = 1'b0;
    if (with_wr) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
      wq_a.push_back(a); wq_d.push_back(d);
    end
    tick();
    ioctl_wr = 1'b0;
    chk("valid_decide", int'(valid), 0);
    tick();
    chk("valid_done", int'(valid), 1);
  endtask

  // Compare the resolved outputs, then poke ext_bs/sc_mode and a stray write in DONE.
  task automatic check_exp(input string tag, input int ebs, input int esc, input int esz);
    chk({tag, "_bs"}, int'(bs), ebs);
    chk({tag, "_sc"}, int'(sc), esc);
    chk({tag, "_size"}, int'(rom_size), esz);
    prev_bs = ebs; prev_sc = esc;
    ext_bs = 4'($urandom_range(0, 15)); sc_mode = 2'($urandom_range(0, 3));
    ioctl_wr = 1'b1; ioctl_addr = 25'($urandom_range(0, 30000)); ioctl_dout = 8'h85;
    tick();
    ioctl_wr = 1'b0;
    chk({tag, "_done_bs"}, int'(bs), ebs);
    chk({tag, "_done_sc"}, int'(sc), esc);
    chk({tag, "_done_size"}, int'(rom_size), esz);
    chk({tag, "_done_valid"}, int'(valid), 1);
  endtask

  initial begin
    int ebs, esc, esz, k, sz, o, p;
    logic [7:0] c, d;
    bit cf;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    ext_bs = '0; sc_mode = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_bs", int'(bs), 0);
    chk("rst_sc", int'(sc), 0);
    chk("rst_size", int'(rom_size), 0);
    chk("rst_valid", int'(valid), 0);

    // 8 KiB of FF: F8 with SC auto-detected
    ext_bs = 0; sc_mode = 0;
    start_load();
    for (int a = 0; a < 8192; a++) begin
      wr_byte(a, 8'hFF);
      if (a == 100) mid_chk(a);
    end
    end_load(0, 0, 8'h00);
    check_exp("ff8k", 1, 1, 8192);

    // E0 signature at 0x100; byte 5 breaks the SC pattern
    ext_bs = 0; sc_mode = 0;
    start_load();
    for (int a = 0; a < 8192; a++) begin
      d = (a == 5) ? 8'h00 : (a == 256) ? 8'h8D : (a == 257) ? 8'hE0 : (a == 258) ? 8'h1F : 8'hFF;
      wr_byte(a, d);
    end
    end_load(0, 0, 8'h00);
    check_exp("e0", 4, 0, 8192);

    // 16 KiB sparse: 85 3F twice -> 3F, once -> F6
    for (int t = 0; t < 2; t++) begin
      ext_bs = 0; sc_mode = 0;
      start_load();
      for (int a = 0; a < 300; a++) begin
        d = (a == 64 || (t == 0 && a == 128)) ? 8'h85 :
            (a == 65 || (t == 0 && a == 129)) ? 8'h3F : 8'h11;
        wr_byte(a, d);
      end
      wr_byte(16383, 8'h11);
      end_load(0, 0, 8'h00);
      check_exp(t == 0 ? "f3f_two" : "f3f_one", t == 0 ? 5 : 2, 0, 16384);
    end

    // Forced bankswitch and SC
    ext_bs = 9; sc_mode = 2;
    start_load();
    for (int a = 0; a < 4096; a++) wr_byte(a, 8'($urandom));
    end_load(0, 0, 8'h00);
    check_exp("ext", 9, 1, 4096);

    // Zero-byte downloads
    ext_bs = 0; sc_mode = 1;
    start_load();
    end_load(0, 0, 8'h00);
    check_exp("zero_auto", 0, 0, 0);
    ext_bs = 3; sc_mode = 3;
    start_load();
    end_load(0, 0, 8'h00);
    check_exp("zero_ext", 3, 1, 0);

    // Reset mid-load with download still high
    ext_bs = 0; sc_mode = 0;
    start_load();
    for (int a = 0; a < 3000; a++) wr_byte(a, 8'hFF);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("mid_rst_bs", int'(bs), 0);
    chk("mid_rst_sc", int'(sc), 0);
    for (int i = 0; i < 30; i++) begin
      ioctl_wr = i[0]; ioctl_addr = 25'(3000 + i); ioctl_dout = 8'hFF;
      tick();
      chk("post_rst_valid", int'(valid), 0);
      chk("post_rst_size", int'(rom_size), 0);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_idle_valid", int'(valid), 0);
      chk("post_rst_idle_size", int'(rom_size), 0);
    end
    prev_bs = 0; prev_sc = 0;
    start_load();
    for (int a = 0; a < 32768; a++) begin
      d = 8'($urandom);
      wr_byte(a, (d == 8'h85) ? 8'h86 : d);
    end
    end_load(0, 0, 8'h00);
    check_exp("f4_32k", 6, 0, 32768);

    // Final byte arrives together with the falling edge
    ext_bs = 0; sc_mode = 0;
    start_load();
    for (int a = 0; a < 300; a++) wr_byte(a, 8'h42);
    end_load(1, 12287, 8'h42);
    check_exp("fall_wr", 8, 1, 12288);

    // Randomized sparse loads against the model
    for (int it = 0; it < 20; it++) begin
      ext_bs  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      sc_mode = 2'($urandom_range(0, 3));
      k  = int'($urandom_range(270, 500));
      cf = ($urandom_range(0, 2) == 0);
      c  = alpha[$urandom_range(0, 17)];
      for (int a = 0; a < k; a++) plan[a] = (cf && a < 256) ? c : alpha[$urandom_range(0, 17)];
      for (int j = 0; j < 2; j++) begin
        p = int'($urandom_range(0, 9));
        o = cf ? int'($urandom_range(256, k - 6)) : int'($urandom_range(0, k - 6));
        for (int b = 0; b < plen[p]; b++) plan[o + b] = pats[p][8*(plen[p] - 1 - b) +: 8];
      end
      sz = sizes[$urandom_range(0, 10)];
      start_load();
      for (int a = 0; a < k; a++) begin
        if ($urandom_range(0, 15) == 0)
          wr_byte(32768 + int'($urandom_range(0, 30000)), alpha[$urandom_range(0, 17)]);
        wr_byte(a, plan[a]);
        if (a == 150) mid_chk(a);
      end
      if ($urandom_range(0, 1) == 1) end_load(1, sz - 1, alpha[$urandom_range(0, 17)]);
      else begin
        wr_byte(sz - 1, alpha[$urandom_range(0, 17)]);
        end_load(0, 0, 8'h00);
      end
      model(ext_bs, sc_mode, ebs, esc, esz);
      check_exp("rnd", ebs, esc, esz);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cart_detect.md
CART_DETECT -- requirements
Module: cart_detect

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port ioctl_download, input, 1, download-in-progress level from the HPS I/O block.
REQ-004 SHALL have port ioctl_wr, input, 1, one-cycle byte write strobe.
REQ-005 SHALL have port ioctl_addr, input, 25, byte address of the current write.
REQ-006 SHALL have port ioctl_dout, input, 8, byte data of the current write.
REQ-007 SHALL have port ext_bs, input, 4, bankswitch code forced by file extension; 0 = auto.
REQ-008 SHALL have port sc_mode, input, 2, SuperChip mode: 0 auto, 1 disable, 2 or 3 enable.
REQ-009 SHALL have port bs, output, 4, resolved bankswitch code to the console core.
REQ-010 SHALL have port sc, output, 1, resolved SuperChip enable.
REQ-011 SHALL have port rom_size, output, 17, loaded image size in bytes.
REQ-012 SHALL have port valid, output, 1, high while bs/sc reflect a completed load.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD on ioctl_download rising edge (edge detected against a 1-cycle delayed copy).
- LOAD -> DECIDE on the falling edge.
- DECIDE -> DONE after exactly 1 cycle.
- DONE -> LOAD on the next rising edge.
REQ-014 SHALL on LOAD entry clear rom_size, all signature flags, the byte window and the SC tracker, and drive valid=0.
REQ-015 SHALL on each ioctl_wr in LOAD set rom_size = min(ioctl_addr+1, 17'h10000), updated live.
REQ-016 SHALL act on writes only in LOAD; ioctl_wr in IDLE or DONE is ignored.
REQ-017 SHALL keep a 5-byte shift window of the most recent written bytes.
- Write with ioctl_addr=0 flushes the window to 5 invalid slots before shifting in the new byte.
- Writes with ioctl_addr[24:15]!=0 do not enter the window.
REQ-018 SHALL set sticky flags when the newest window bytes, oldest first, match:
- E0: 8D E0 1F | 8D E0 5F | 8D E9 FF | AD E0 1F.
- 3F: 85 3F, second occurrence only; a 2-bit counter saturates at 2.
- FE: 20 00 D0 C6 C5.
- E7: AD E2 FF | AD E5 FF.
- UA: 8D 40 02 | AD 40 02.
REQ-019 SHALL use partial window contents only where enough valid slots exist; invalid slots never match.
REQ-020 SHALL track SC-auto as true iff bytes at addresses 0..255 are all equal to the byte at address 0 and at least 256 bytes were written.
REQ-021 SHALL in DECIDE set bs by the first matching rule:
- ext_bs!=0 -> ext_bs.
- size<=4096 -> 0.
- size=8192: E0->4, 3F->5, FE->3, UA->11, else 1.
- size=10495 -> 7.
- size=12288 -> 8.
- size=16384: E7->12, 3F->5, else 2.
- size=32768: 3F->5, else 6.
- otherwise: 3F->5, else 0.
REQ-022 SHALL in DECIDE set sc = sc_mode==0 ? (SC-auto && size in {8192,12288,16384}) : sc_mode[1].
REQ-023 SHALL register bs, sc and valid in DECIDE.
- valid=1 on the first DONE cycle, 2 cycles after ioctl_download falls.
- bs/sc hold their previous values through LOAD.
REQ-024 SHALL leave DONE outputs unaffected by changes to ext_bs/sc_mode until the next load.
REQ-025 SHALL handle the same cycle as the download falling edge with ioctl_wr high as a counted write, included before DECIDE.
REQ-026 SHALL treat a zero-byte download (rise then fall, no writes) as rom_size=0 and bs=0 (ext_bs=0), or bs=ext_bs otherwise.

Reset
REQ-027 SHALL on reset force state=IDLE and bs=0, sc=0, rom_size=0, valid=0, and clear all flags, the window and the edge register.
REQ-028 SHALL when reset is asserted mid-LOAD discard the partial load and remain in IDLE until a fresh ioctl_download rising edge; a download still high after reset is not captured.

Verification
REQ-029 SHALL cover: 8192 bytes of FF, ext_bs=0, sc_mode=0 -> rom_size=8192, bs=1, sc=1, valid 2 cycles after the falling edge.
REQ-030 SHALL cover: 8192 bytes containing 8D E0 1F at 0x100, byte 0x00 at address 5 -> bs=4, sc=0.
REQ-031 SHALL cover: 16384 bytes with 85 3F at two offsets -> bs=5; with one offset only -> bs=2.
REQ-032 SHALL cover: 4096 bytes with ext_bs=9, sc_mode=2 -> bs=9, sc=1, rom_size=4096.
REQ-033 SHALL cover: reset after 3000 bytes of a 8192-byte load, download still high -> valid=0 and rom_size=0 held to the end; next full 32768-byte load -> bs=6.
REQ-034 SHALL cover: last write coincident with the download falling edge, addr 12287 -> rom_size=12288, bs=8.
